shift_reg_64: RTL and testbench

Parallel-in, serial-out 64-bit shift register for the controller-emulation datapath. It captures a full frame of button/axis data on a latch strobe, then presents it one bit at a time on a serial output line as the protocol engine requests each bit. It is instantiated by the controller front end (`gc_controller`), which drives the data wire from its serial output.

---
 rtl/ctrl_pkg.sv | 9 +
 rtl/shift_reg_64.sv | 53 +++++
 tb/tb_shift_reg_64.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the controller-emulation datapath: frame length,
// count width and the level the serial line rests at between frames.
package ctrl_pkg;

  localparam int   FRAME_BITS     = 64;
  localparam int   CNT_W          = $clog2(FRAME_BITS + 1);
  localparam logic IDLE_LEVEL_DEF = 1'b1;

endpackage

// File: rtl/shift_reg_64.sv
// Parallel-in, serial-out frame shifter; MSB first by default, LSB first
// when SHIFT_REG_64_LSB_FIRST_EN is defined.
module shift_reg_64
  import ctrl_pkg::*;
#(
  parameter int   WIDTH      = FRAME_BITS,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lat,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             d,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] shreg;

  // Load takes priority over shift; shifts on an empty register only clear done.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
      done  <= 1'b0;
    end else if (lat) begin
      shreg <= data;
      count <= CNT_W'(WIDTH);
      done  <= 1'b0;
    end else if (shift && (count != '0)) begin
`ifdef SHIFT_REG_64_LSB_FIRST_EN
      shreg <= shreg >> 1;
`else
      shreg <= shreg << 1;
`endif
      count <= count - CNT_W'(1);
      done  <= (count == CNT_W'(1));
    end else begin
      done  <= 1'b0;
    end
  end

  assign busy = (count != '0);

`ifdef SHIFT_REG_64_LSB_FIRST_EN
  assign d = busy ? shreg[0] : IDLE_LEVEL;
`else
  assign d = busy ? shreg[WIDTH-1] : IDLE_LEVEL;
`endif

endmodule

// File: tb/tb_shift_reg_64.sv
// Directed bench for shift_reg_64: reset, full frame, abort-by-reload,
// load/shift collision and shifting while empty.
module tb_shift_reg_64;

  logic        clk;
  logic        rst;
  logic        lat;
  logic        shift;
  logic [63:0] data;
  logic        d;
  logic        busy;
  logic [6:0]  count;
  logic        done;

  int checks = 0;
  int errors = 0;

  shift_reg_64 dut (
    .clk   (clk),
    .rst   (rst),
    .lat   (lat),
    .shift (shift),
    .data  (data),
    .d     (d),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit expected on d after n shifts of a freshly loaded frame.
  function automatic logic bit_after(input logic [63:0] frame, input int n);
`ifdef SHIFT_REG_64_LSB_FIRST_EN
    return frame[n];
`else
    return frame[63-n];
`endif
  endfunction

  task automatic load(input logic [63:0] v);
    data = v;
    lat  = 1'b1;
    tick();
    lat  = 1'b0;
  endtask

  logic [63:0] frame;

  initial begin
    rst = 1'b1; lat = 1'b1; shift = 1'b1; data = '1;
    tick();
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_d",     64'(d),     64'd1);
    check("rst_done",  64'(done),  64'd0);

    rst = 1'b0; lat = 1'b0; shift = 1'b0;
    tick();
    check("idle_count", 64'(count), 64'd0);

    // Full frame, back-to-back shifts
    frame = 64'h8000_0000_0000_0001;
    load(frame);
    check("load_count", 64'(count), 64'd64);
    check("load_busy",  64'(busy),  64'd1);
    tick();
    tick();
    check("hold_count", 64'(count), 64'd64);
    for (int i = 0; i < 64; i++) begin
      check("frame_d", 64'(d), 64'(bit_after(frame, i)));
      shift = 1'b1;
      tick();
      check("frame_count", 64'(count), 64'(63 - i));
      check("frame_done",  64'(done),  64'(i == 63));
    end
    shift = 1'b0;
    check("end_d",    64'(d),    64'd1);
    check("end_busy", 64'(busy), 64'd0);
    tick();
    check("end_done_clr", 64'(done), 64'd0);

    // Reload mid-frame aborts the old one
    frame = 64'hA5A5_5A5A_F00F_1234;
    load(frame);
    check("a5_d0", 64'(d), 64'(bit_after(frame, 0)));
    shift = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    shift = 1'b0;
    check("a5_count10", 64'(count), 64'd54);
    check("a5_d10",     64'(d),     64'(bit_after(frame, 10)));
    load(64'h0);
    check("abort_count", 64'(count), 64'd64);
    check("abort_d",     64'(d),     64'd0);
    check("abort_done",  64'(done),  64'd0);

    // Load and shift together: load wins
    data = '1; lat = 1'b1; shift = 1'b1;
    tick();
    lat = 1'b0; shift = 1'b0;
    check("collide_count", 64'(count), 64'd64);
    check("collide_d",     64'(d),     64'd1);

    // Shifting while empty
    rst = 1'b1;
    tick();
    rst = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_count", 64'(count), 64'd0);
      check("empty_done",  64'(done),  64'd0);
      check("empty_d",     64'(d),     64'd1);
    end
    shift = 1'b0;

`ifdef SHIFT_REG_64_LSB_FIRST_EN
    load(64'h1);
    check("lsb_d_before", 64'(d), 64'd1);
    shift = 1'b1;
    tick();
    shift = 1'b0;
    check("lsb_d_after", 64'(d), 64'd0);
`else
    load(64'h1);
    check("msb_d_before", 64'(d), 64'd0);
    shift = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    shift = 1'b0;
    check("msb_d_last",   64'(d),     64'd1);
    check("msb_count1",   64'(count), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
